// File: rtl/mem_arb_rr.sv
// mem_arb_rr - N-port arbiter for the native valid/ready memory bus.
//
// Merges NPORTS requesters onto one memory master port. The grant is
// registered, so there is never a combinational path from s_valid to m_valid.
// Selection is round-robin (MODE=0) or fixed priority, lowest index first
// (MODE=1). An optional watchdog (TIMEOUT>0) aborts a transaction that has
// waited TIMEOUT busy cycles without m_ready and returns an error to the port.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_valid[i]      request from port i, held until s_ready[i]
//   s_ready[i]      completion strobe to port i (combinational from m_ready)
//   s_err[i]        watchdog abort flag, qualified by s_ready[i]
//   s_addr/wdata/wstrb  flattened per-port request fields, port i at [i*W +: W]
//   s_rdata         read data broadcast to all ports, all-ones on abort
//   m_valid/m_ready master handshake; m_addr/m_wdata/m_wstrb from granted port
//   m_rdata         master read data
//   grant_idx       currently granted port, meaningful while m_valid
module mem_arb_rr #(
  parameter int NPORTS  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0,
  parameter int IDX_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          s_valid,
  output logic [NPORTS-1:0]          s_ready,
  output logic [NPORTS-1:0]          s_err,
  input  logic [NPORTS*ADDR_W-1:0]   s_addr,
  input  logic [NPORTS*DATA_W-1:0]   s_wdata,
  input  logic [NPORTS*DATA_W/8-1:0] s_wstrb,
  output logic [DATA_W-1:0]          s_rdata,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic [DATA_W-1:0]          m_rdata,
  output logic [IDX_W-1:0]           grant_idx
);
  localparam int STRB_W = DATA_W / 8;
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NPORTS - 1);

  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

  logic              timeout_hit, done, found;
  logic [NPORTS-1:0] cand;
  logic [IDX_W-1:0]  winner, ref_idx;
  int unsigned       p;

  logic [ADDR_W-1:0] addr_a  [NPORTS];
  logic [DATA_W-1:0] wdata_a [NPORTS];
  logic [STRB_W-1:0] wstrb_a [NPORTS];

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign addr_a[i]  = s_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = s_wdata[i*DATA_W +: DATA_W];
    assign wstrb_a[i] = s_wstrb[i*STRB_W +: STRB_W];
    assign s_ready[i] = done && (grant_q == IDX_W'(i));
  end

  // With TIMEOUT=0 the compare is masked by a constant, so the counter is
  // dead logic and the abort path disappears.
  assign timeout_hit = (TIMEOUT > 0) && (wd_cnt_q == WD_LAST) && !m_ready;
  assign done        = busy_q && (m_ready || timeout_hit);
  assign s_err       = s_ready & {NPORTS{~m_ready}};
  assign s_rdata     = m_ready ? m_rdata : {DATA_W{1'b1}};

  assign m_valid   = busy_q;
  assign m_addr    = addr_a[grant_q];
  assign m_wdata   = wdata_a[grant_q];
  assign m_wstrb   = wstrb_a[grant_q];
  assign grant_idx = grant_q;

  always_comb begin
    // The completing port still shows s_valid this cycle; that request is
    // being answered now, so it must not win the next slot.
    cand = s_valid;
    if (done) cand[grant_q] = 1'b0;

    found   = 1'b0;
    winner  = '0;
    p       = 0;
    ref_idx = done ? grant_q : last_q;
    if (MODE == 0) begin
      for (int k = 1; k <= NPORTS; k++) begin
        p = (int'(ref_idx) + k) % NPORTS;
        if (!found && cand[p]) begin
          found  = 1'b1;
          winner = IDX_W'(p);
        end
      end
    end else begin
      // Descending scan so the lowest index is the last to overwrite.
      for (int k = NPORTS - 1; k >= 0; k--) begin
        if (cand[k]) begin
          found  = 1'b1;
          winner = IDX_W'(k);
        end
      end
    end

    busy_d  = busy_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (!busy_q || done) begin
      busy_d = found;
      if (found) begin
        grant_d = winner;
        last_d  = winner;
      end
    end

    wd_cnt_d = (busy_q && !m_ready && !done) ? wd_cnt_q + WD_W'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      grant_q  <= '0;
      last_q   <= LAST_RST;
      wd_cnt_q <= '0;
    end else begin
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end
endmodule
